stream_demux_reg: RTL

STREAM_DEMUX_REG -- requirements
Module: stream_demux_reg

---
 rtl/stream_demux_reg.sv | 91 +++++++++
 1 files changed

// File: rtl/stream_demux_reg.sv
// Registered 1-to-N stream demux, one 2-entry FIFO per output.
// Define STREAM_DEMUX_REG_DROP_EN to drop and count out-of-range beats.
module stream_demux_reg #(
  parameter int DATA_W    = 1,
  parameter int N_OUP     = 2,
  parameter int LOG_N_OUP = (N_OUP > 1) ? $clog2(N_OUP) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [DATA_W-1:0]              inp_data_i,
  input  logic                           inp_valid_i,
  output logic                           inp_ready_o,
  input  logic [LOG_N_OUP-1:0]           inp_sel_i,
  output logic [N_OUP-1:0][DATA_W-1:0]   oup_data_o,
  output logic [N_OUP-1:0]               oup_valid_o,
  input  logic [N_OUP-1:0]               oup_ready_i,
  output logic [15:0]                    drop_cnt_o
);

  localparam logic [31:0] N_U = 32'(N_OUP);

  logic             in_range;
  logic             sel_full;
  logic [N_OUP-1:0] full;

  assign in_range = (32'(inp_sel_i) < N_U);

  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < N_OUP; i++) begin
      if (inp_sel_i == LOG_N_OUP'(i) && full[i]) sel_full = 1'b1;
    end
  end

`ifdef STREAM_DEMUX_REG_DROP_EN
  logic drop;

  assign inp_ready_o = !in_range || !sel_full;
  assign drop        = inp_valid_i && !in_range;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_o <= '0;
    end else if (drop && drop_cnt_o != 16'hFFFF) begin
      drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`else
  assign inp_ready_o = in_range && !sel_full;
  assign drop_cnt_o  = '0;
`endif

  for (genvar g = 0; g < N_OUP; g++) begin : g_oup
    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;

    assign push = inp_valid_i && inp_ready_o && in_range &&
                  (inp_sel_i == LOG_N_OUP'(g));
    assign pop  = oup_valid_o[g] && oup_ready_i[g];

    assign full[g]        = (count == 2'd2);
    assign oup_valid_o[g] = (count != 2'd0);
    assign oup_data_o[g]  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end

    // storage is left unreset; pointers gate what becomes visible
    always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= inp_data_i;
    end
  end

endmodule
